// File: rtl/tlb_translate_unit.sv
// Virtual-to-physical translation front stage: fully-associative TLB tagged by
// VPN+ASID, single-level page-table walk on miss, and a windowed hit-rate counter.
//
// state  | meaning
// IDLE   | ready for a request
// LOOKUP | one-cycle associative compare against cached entries
// WALK   | page-table read outstanding, waiting for mem_ack
// RESP   | result presented until taken
module tlb_translate_unit #(
    parameter int ENTRIES     = 4,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_virtual_memory,
    input  logic [7:0] page_table_base,
    input  logic [7:0] process_id,
    input  logic       flush,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] vaddr,
    input  logic       is_write,
    input  logic [1:0] privilege_level,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] paddr,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] tlb_hit_rate
);

    localparam int IW = $clog2(ENTRIES);
    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] WIN_LEN = {1'b1, {WINDOW_LOG2{1'b0}}};

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_NOTPRES = 2'b01;
    localparam logic [1:0] FC_PRIV    = 2'b10;
    localparam logic [1:0] FC_WPROT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_t;

    state_t state, state_nx;

    logic [7:0]  req_va;
    logic        req_wr;
    logic        req_user;
    logic [7:0]  req_asid;
    logic [7:0]  mem_addr_q;
    logic [7:0]  paddr_q;
    logic        fault_q;
    logic [1:0]  code_q;

    logic [ENTRIES-1:0] ent_valid;
    logic [3:0]         ent_vpn  [ENTRIES];
    logic [7:0]         ent_asid [ENTRIES];
    logic [3:0]         ent_pfn  [ENTRIES];
    logic               ent_user [ENTRIES];
    logic               ent_wr   [ENTRIES];
    logic [IW-1:0]      rr_ptr;

    logic [CW-1:0] lookup_cnt;
    logic [CW-1:0] hit_cnt;
    logic [7:0]    hit_rate_q;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] fill_idx;
    logic          fill_en;
    logic [1:0]    lk_code;
    logic [1:0]    wk_code;
    logic          accept;

    function automatic logic [1:0] perm_code(input logic present, input logic user_ok,
                                             input logic writable, input logic usr,
                                             input logic wr);
        if (!present)
            return FC_NOTPRES;
        else if (usr && !user_ok)
            return FC_PRIV;
        else if (wr && !writable)
            return FC_WPROT;
        else
            return FC_NONE;
    endfunction

    assign req_ready    = (state == S_IDLE);
    assign resp_valid   = (state == S_RESP);
    assign mem_req      = (state == S_WALK);
    assign mem_addr     = mem_addr_q;
    assign paddr        = paddr_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
    assign tlb_hit_rate = hit_rate_q;
    assign accept       = req_valid && (state == S_IDLE);

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && ent_valid[i] && ent_vpn[i] == req_va[7:4] && ent_asid[i] == req_asid) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!free_found && !ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign fill_idx = free_found ? free_idx : rr_ptr;
    assign fill_en  = (state == S_WALK) && mem_ack && mem_rdata[7] && !flush;
    assign lk_code  = perm_code(1'b1, ent_user[hit_idx], ent_wr[hit_idx], req_user, req_wr);
    assign wk_code  = perm_code(mem_rdata[7], mem_rdata[6], mem_rdata[5], req_user, req_wr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (req_valid) state_nx = enable_virtual_memory ? S_LOOKUP : S_RESP;
            S_LOOKUP: state_nx = hit ? S_RESP : S_WALK;
            S_WALK:   if (mem_ack) state_nx = S_RESP;
            S_RESP:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Request context is frozen at accept so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_va     <= '0;
            req_wr     <= 1'b0;
            req_user   <= 1'b0;
            req_asid   <= '0;
            mem_addr_q <= '0;
            paddr_q    <= '0;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
        end else begin
            if (accept) begin
                req_va     <= vaddr;
                req_wr     <= is_write;
                req_user   <= (privilege_level != 2'b00);
                req_asid   <= process_id;
                mem_addr_q <= page_table_base + {4'b0000, vaddr[7:4]};
                if (!enable_virtual_memory) begin
                    paddr_q <= vaddr;
                    fault_q <= 1'b0;
                    code_q  <= FC_NONE;
                end
            end
            if (state == S_LOOKUP && hit) begin
                paddr_q <= (lk_code == FC_NONE) ? {ent_pfn[hit_idx], req_va[3:0]} : 8'h00;
                fault_q <= (lk_code != FC_NONE);
                code_q  <= lk_code;
            end
            if (state == S_WALK && mem_ack) begin
                paddr_q <= (wk_code == FC_NONE) ? {mem_rdata[3:0], req_va[3:0]} : 8'h00;
                fault_q <= (wk_code != FC_NONE);
                code_q  <= wk_code;
            end
        end
    end

    // Flush beats a coincident fill; the victim pointer only moves on an evicting fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_vpn[i]  <= '0;
                ent_asid[i] <= '0;
                ent_pfn[i]  <= '0;
                ent_user[i] <= 1'b0;
                ent_wr[i]   <= 1'b0;
            end
        end else if (flush) begin
            ent_valid <= '0;
        end else if (fill_en) begin
            ent_valid[fill_idx] <= 1'b1;
            ent_vpn[fill_idx]   <= req_va[7:4];
            ent_asid[fill_idx]  <= req_asid;
            ent_pfn[fill_idx]   <= mem_rdata[3:0];
            ent_user[fill_idx]  <= mem_rdata[6];
            ent_wr[fill_idx]    <= mem_rdata[5];
            if (!free_found)
                rr_ptr <= rr_ptr + 1'b1;
        end
    end

    logic [CW-1:0] lookup_nx;
    logic [CW-1:0] hit_total;

    assign lookup_nx = lookup_cnt + 1'b1;
    assign hit_total = hit_cnt + CW'(hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookup_cnt <= '0;
            hit_cnt    <= '0;
            hit_rate_q <= '0;
        end else if (state == S_LOOKUP) begin
            if (lookup_nx == WIN_LEN) begin
                hit_rate_q <= (32'(hit_total) > 32'd255) ? 8'hFF : 8'(hit_total);
                lookup_cnt <= '0;
                hit_cnt    <= '0;
            end else begin
                lookup_cnt <= lookup_nx;
                hit_cnt    <= hit_total;
            end
        end
    end

endmodule

// File: tb/tb_tlb_translate_unit.sv
// Directed bench for tlb_translate_unit: hand-computed translations, faults,
// eviction, flush, bypass, address wrap, hit-rate windows and async reset.
module tb_tlb_translate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_virtual_memory;
    logic [7:0] page_table_base;
    logic [7:0] process_id;
    logic       flush;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] vaddr;
    logic       is_write;
    logic [1:0] privilege_level;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] paddr;
    logic       fault;
    logic [1:0] fault_code;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] tlb_hit_rate;

    int n_chk  = 0;
    int n_pass = 0;

    tlb_translate_unit #(.ENTRIES(4), .WINDOW_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .enable_virtual_memory(enable_virtual_memory),
        .page_table_base(page_table_base), .process_id(process_id),
        .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .vaddr(vaddr), .is_write(is_write), .privilege_level(privilege_level),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .paddr(paddr),
        .fault(fault), .fault_code(fault_code), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .tlb_hit_rate(tlb_hit_rate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    // One request; pte/exp_ma only matter when a walk is expected.
    task automatic txn(input string tag, input logic [7:0] va, input logic wr,
                       input logic [1:0] pl, input logic exp_walk, input logic [7:0] exp_ma,
                       input logic [7:0] pte, input logic [7:0] exp_pa,
                       input logic [1:0] exp_code, input int hold, input logic flush_ack);
        int  n;
        bit  walked;
        bit  done;
        logic [7:0] pa_held;
        n = 0;
        walked = 0;
        done = 0;
        @(negedge clk);
        vaddr = va;
        is_write = wr;
        privilege_level = pl;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_ma));
                walked = 1;
                mem_rdata = pte;
                mem_ack = 1'b1;
                flush = flush_ack;
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                flush = 1'b0;
            end else if (resp_valid) begin
                chk({tag, " walk"}, 32'(walked), 32'(exp_walk));
                chk({tag, " paddr"}, 32'(paddr), 32'(exp_pa));
                chk({tag, " fault"}, 32'(fault), 32'(exp_code != 2'b00));
                chk({tag, " code"}, 32'(fault_code), 32'(exp_code));
                if (!exp_walk)
                    chk({tag, " latency"}, 32'(n), enable_virtual_memory ? 32'd2 : 32'd1);
                pa_held = paddr;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
                    chk({tag, " hold paddr"}, 32'(paddr), 32'(pa_held));
                    chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
                end
                resp_ready = 1'b1;
                @(posedge clk);
                #1 resp_ready = 1'b0;
                done = 1;
            end
        end
        if (!done)
            chk({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        enable_virtual_memory = 1'b1;
        page_table_base = 8'h80;
        process_id = 8'd3;
        flush = 1'b0;
        req_valid = 1'b0;
        vaddr = '0;
        is_write = 1'b0;
        privilege_level = 2'd0;
        resp_ready = 1'b0;
        mem_rdata = '0;
        mem_ack = 1'b0;
        #22;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst paddr", 32'(paddr), 32'd0);
        chk("rst fault_code", 32'(fault_code), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst hit_rate", 32'(tlb_hit_rate), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // basic fill, hit, stall, permission faults
        txn("t1 miss", 8'h25, 0, 2'd0, 1, 8'h82, 8'hC7, 8'h75, 2'b00, 0, 0);
        txn("t2 hit", 8'h2A, 0, 2'd0, 0, 8'h00, 8'h00, 8'h7A, 2'b00, 5, 0);
        txn("t3 priv", 8'h31, 1, 2'd3, 1, 8'h83, 8'h87, 8'h00, 2'b10, 0, 0);
        txn("t3 priv cached", 8'h31, 1, 2'd3, 0, 8'h00, 8'h00, 8'h00, 2'b10, 0, 0);
        txn("t4 wprot", 8'h42, 1, 2'd3, 1, 8'h84, 8'hC7, 8'h00, 2'b11, 0, 0);
        txn("t5 notpres", 8'h63, 0, 2'd0, 1, 8'h86, 8'h00, 8'h00, 2'b01, 0, 0);
        txn("t5 notpres again", 8'h63, 0, 2'd0, 1, 8'h86, 8'h00, 8'h00, 2'b01, 0, 0);
        txn("t6 kernel wr ro", 8'h20, 1, 2'd0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 0, 0);
        txn("t6 user rd", 8'h2F, 0, 2'd1, 0, 8'h00, 8'h00, 8'h7F, 2'b00, 0, 0);

        // round-robin eviction and ASID tagging
        pulse_flush();
        txn("ev 8", 8'h80, 0, 2'd0, 1, 8'h88, 8'hE1, 8'h10, 2'b00, 0, 0);
        txn("ev 9", 8'h91, 0, 2'd0, 1, 8'h89, 8'hE2, 8'h21, 2'b00, 0, 0);
        txn("ev A", 8'hA2, 0, 2'd0, 1, 8'h8A, 8'hE3, 8'h32, 2'b00, 0, 0);
        txn("ev B", 8'hB3, 0, 2'd0, 1, 8'h8B, 8'hE4, 8'h43, 2'b00, 0, 0);
        txn("ev C", 8'hC4, 0, 2'd0, 1, 8'h8C, 8'hE5, 8'h54, 2'b00, 0, 0);
        txn("ev 8 evicted", 8'h85, 0, 2'd0, 1, 8'h88, 8'hE1, 8'h15, 2'b00, 0, 0);
        txn("ev A kept", 8'hA6, 0, 2'd0, 0, 8'h00, 8'h00, 8'h36, 2'b00, 0, 0);
        txn("ev 9 evicted", 8'h97, 0, 2'd0, 1, 8'h89, 8'hE2, 8'h27, 2'b00, 0, 0);
        process_id = 8'd4;
        txn("asid 4 miss", 8'hC8, 0, 2'd0, 1, 8'h8C, 8'hE5, 8'h58, 2'b00, 0, 0);
        process_id = 8'd3;
        txn("asid 3 hit", 8'hC9, 0, 2'd0, 0, 8'h00, 8'h00, 8'h59, 2'b00, 0, 0);

        // flush coincident with fill
        txn("flush@ack", 8'hD0, 0, 2'd0, 1, 8'h8D, 8'hE6, 8'h60, 2'b00, 0, 1);
        txn("after flush D", 8'hD1, 0, 2'd0, 1, 8'h8D, 8'hE6, 8'h61, 2'b00, 0, 0);
        txn("after flush C", 8'hC9, 0, 2'd0, 1, 8'h8C, 8'hE5, 8'h59, 2'b00, 0, 0);

        // bypass and base wrap
        enable_virtual_memory = 1'b0;
        txn("bypass", 8'hF3, 1, 2'd3, 0, 8'h00, 8'h00, 8'hF3, 2'b00, 0, 0);
        enable_virtual_memory = 1'b1;
        page_table_base = 8'hFE;
        txn("wrap", 8'h5A, 0, 2'd0, 1, 8'h03, 8'hC9, 8'h9A, 2'b00, 0, 0);

        // hit-rate windows from a clean counter state
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        page_table_base = 8'h80;
        for (int i = 0; i < 64; i++) begin
            pulse_flush();
            txn("hr miss", 8'h10, 0, 2'd0, 1, 8'h81, 8'hC5, 8'h50, 2'b00, 0, 0);
            txn("hr hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
            txn("hr hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
            if (i == 10 || i == 40) begin
                enable_virtual_memory = 1'b0;
                txn("hr bypass", 8'h44, 0, 2'd0, 0, 8'h00, 8'h00, 8'h44, 2'b00, 0, 0);
                enable_virtual_memory = 1'b1;
            end
        end
        for (int i = 0; i < 63; i++)
            txn("hr hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
        chk("rate before 256th", 32'(tlb_hit_rate), 32'd0);
        txn("hr hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
        chk("rate 192", 32'(tlb_hit_rate), 32'd192);
        for (int i = 0; i < 255; i++)
            txn("hr all hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
        chk("rate held 192", 32'(tlb_hit_rate), 32'd192);
        txn("hr all hit", 8'h1F, 0, 2'd0, 0, 8'h00, 8'h00, 8'h5F, 2'b00, 0, 0);
        chk("rate sat 255", 32'(tlb_hit_rate), 32'd255);

        // async reset in the middle of a walk
        begin
            int w;
            w = 0;
            @(negedge clk);
            vaddr = 8'h70;
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            while (!mem_req && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("walk started", 32'(mem_req), 32'd1);
            #2 rst = 1'b0;
            #1;
            chk("arst mem_req", 32'(mem_req), 32'd0);
            chk("arst req_ready", 32'(req_ready), 32'd1);
            chk("arst hit_rate", 32'(tlb_hit_rate), 32'd0);
            chk("arst resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
            rst = 1'b1;
        end
        txn("post-rst miss", 8'h1F, 0, 2'd0, 1, 8'h81, 8'hC5, 8'h5F, 2'b00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tlb_translate_unit.md
Name: tlb_translate_unit

Overview:
- Address-translation front stage that feeds the unified advanced CPU's virtual-memory path and produces its tlb_hit_rate status.
- Accepts 8-bit virtual addresses (4-bit VPN, 4-bit offset) and looks them up in a small fully-associative TLB tagged by VPN and process ID.
- On a miss it walks a single-level page table in memory, fills the TLB, and returns a physical address or a fault code.
- Tracks hits per window of lookups and reports a hit-rate metric.

Parameters:
ENTRIES, 4, number of TLB entries (power of 2, 2..8)
WINDOW_LOG2, 8, log2 of lookups per hit-rate window

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
enable_virtual_memory  input  1  1 = translate, 0 = bypass; sampled at request accept
page_table_base  input  8  page-table base address
process_id  input  8  current ASID; sampled at accept
flush  input  1  single-cycle pulse; invalidate all TLB entries
req_valid  input  1  translation request valid
req_ready  output  1  high only in IDLE
vaddr  input  8  virtual address
is_write  input  1  request is a store
privilege_level  input  2  0 = kernel; any nonzero value = user
resp_valid  output  1  response valid, held until taken
resp_ready  input  1  consumer accepts response
paddr  output  8  physical address {PFN, offset}
fault  output  1  translation fault
fault_code  output  2  01 not-present, 10 privilege, 11 write-protect, 00 none
mem_req  output  1  page-table read request, held until ack
mem_addr  output  8  PTE address
mem_rdata  input  8  PTE data, valid with mem_ack
mem_ack  input  1  one-cycle read completion
tlb_hit_rate  output  8  hits in last completed window, saturated to 255

Behaviour:
- Reset (rst low, async): all entries invalid; FSM to IDLE; req_ready=1; resp_valid, mem_req, fault=0; paddr, fault_code, mem_addr=0; tlb_hit_rate=0; window counters=0. mem_req drops immediately even mid-walk.
- PTE format: [7] present, [6] user-accessible, [5] writable, [3:0] PFN.
- Entry contents: valid, VPN[3:0], ASID[7:0], PFN, user, writable.
- FSM states: IDLE, LOOKUP, WALK, RESP.
- IDLE: on req_valid && req_ready, register vaddr, is_write, privilege level, process_id and enable.
  - Enabled: go to LOOKUP.
  - Bypass: go to RESP with paddr=vaddr, fault=0. Bypass requests are not counted in the hit rate.
- LOOKUP (one cycle): hit = valid && VPN match && ASID match.
  - Hit: go to RESP; paddr={PFN,offset}; permission check from cached bits.
  - Miss: go to WALK.
  - Result: a hit response is valid after the 2nd rising edge following acceptance.
- WALK: mem_req=1, mem_addr=page_table_base+{4'b0,VPN}, modulo 256 (wraps). mem_addr is stable while mem_req is high. On mem_ack, capture mem_rdata and go to RESP.
  - PTE present: fill the first invalid entry, else the round-robin victim. The round-robin pointer advances only on a fill that evicts.
  - Not-present PTE: never cached.
- Fault priority: not-present > privilege (user request to a page with user=0) > write-protect (is_write to a page with writable=0). Faulting accesses still fill the TLB if the PTE is present. On fault, paddr=0.
- RESP: resp_valid=1; paddr, fault and fault_code stable. Go to IDLE on resp_ready. Back-to-back operation: a new request is accepted the cycle after the response is taken.
- Flush: invalidates all entries at the next edge, in any state.
  - Flush in the same cycle as a fill: flush wins, no entry written; the in-flight response still completes normally.
  - Flush in the same cycle as LOOKUP: the lookup uses pre-flush contents.
- Hit rate: each completed enabled lookup increments a lookup counter, and a hit counter if it was a TLB hit (walk fills do not count as hits). When the lookup count reaches 2^WINDOW_LOG2, tlb_hit_rate <= min(hits including the current one, 255) and both counters clear in the same cycle.
- Changes to enable_virtual_memory, process_id or page_table_base mid-transaction do not affect the transaction in progress.

Test Plan:
- Reset, enable=1, base=0x80, pid=3, vaddr=0x25, PTE@0x82=0xC7 -> mem_req with mem_addr=0x82; after ack resp paddr=0x75, fault=0; repeat vaddr=0x2A -> hit, no mem_req, paddr=0x7A, resp_valid 2 edges after accept.
- User priv=3, is_write=1, PTE=0x87 (present, not user) -> fault=1, code=10; PTE=0xC7 with write -> code=11; PTE=0x00 -> code=01, entry not cached (next access walks again).
- Fill 5 distinct VPNs with ENTRIES=4, then re-access the first VPN -> miss (evicted); pid change to 4 with same VPN -> miss; flush pulse on same cycle as mem_ack -> response OK, next access misses.
- enable=0, vaddr=0xF3 -> paddr=0xF3, no mem_req, fault=0, hit counters unchanged; base=0xFE, VPN=5 -> mem_addr=0x03 (wrap).
- 256 enabled lookups with 192 hits -> tlb_hit_rate=192 after 256th; 256 all-hit lookups -> 255; resp_ready held low 5 cycles -> outputs stable, req_ready=0.
- Assert rst low during WALK with mem_req high -> mem_req=0 immediately, all entries invalid, tlb_hit_rate=0, req_ready=1.
